// File: rtl/fpu_req_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_req_arbiter
//
// Shares one FPU (ADD/MUL/DIV) between N_REQ client engines. Requests are
// granted round-robin, one operation is in flight at a time, the command and
// operands presented to the FPU stay constant until the FPU answers, and the
// owning client gets a one-cycle response pulse. A watchdog aborts an
// operation that the FPU never completes.
//
// Parameters
//   N_REQ    number of requesters (>= 2)
//   TIMEOUT  cycles spent waiting for the FPU before the op is aborted (>= 2)
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid[i]          requester i has an op pending (held until req_ready[i])
//   req_cmd[2i+:2]        op code of requester i: 1=ADD 2=MUL 3=DIV, 0=illegal
//   req_din1/2[32i+:32]   operands A/B of requester i (IEEE-754 single)
//   req_ready[i]          one-cycle accept pulse to the granted requester
//   rsp_valid[i]          one-cycle completion pulse to the owning requester
//   rsp_result, rsp_err   response data / error flag, hold their last value
//   busy                  high whenever an op is being handled
//   fpu_cmd/din1/din2     command and operands to the FPU
//   fpu_valid             one-cycle start pulse to the FPU
//   fpu_ready/fpu_result  completion handshake and result from the FPU
//
// Timing: accept at T, fpu_valid at T+1, fpu_ready at T+1+L (L >= 1),
// rsp_valid at T+2+L. Illegal command: rsp_valid at T+1.
// -----------------------------------------------------------------------------
module fpu_req_arbiter #(
   parameter int N_REQ   = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [2*N_REQ-1:0]    req_cmd,
   input  logic [32*N_REQ-1:0]   req_din1,
   input  logic [32*N_REQ-1:0]   req_din2,
   output logic [N_REQ-1:0]      req_ready,
   output logic [N_REQ-1:0]      rsp_valid,
   output logic [31:0]           rsp_result,
   output logic                  rsp_err,
   output logic                  busy,
   output logic [1:0]            fpu_cmd,
   output logic [31:0]           fpu_din1,
   output logic [31:0]           fpu_din2,
   output logic                  fpu_valid,
   input  logic                  fpu_ready,
   input  logic [31:0]           fpu_result
);

   localparam int DATA_W = 32;
   localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                state_q;
   state_t                state_d;

   logic [ID_W-1:0]       rr_q;
   logic [ID_W-1:0]       id_q;
   logic [1:0]            cmd_q;
   logic [DATA_W-1:0]     din1_q;
   logic [DATA_W-1:0]     din2_q;
   logic [DATA_W-1:0]     res_q;
   logic                  err_q;
   logic [CNT_W-1:0]      cnt_q;

   logic                  hit;
   logic [ID_W-1:0]       gnt_id;
   logic [1:0]            gnt_cmd;
   logic [DATA_W-1:0]     gnt_a;
   logic [DATA_W-1:0]     gnt_b;
   logic                  timed_out;

   // Requester after id, wrapping N_REQ-1 -> 0 (N_REQ need not be a power of 2).
   function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id);
      if (int'(id) == N_REQ - 1) begin
         return '0;
      end
      return id + ID_W'(1);
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
      logic [N_REQ-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   // Round-robin search starting at the pointer; first pending requester wins.
   always_comb begin
      int idx;
      idx     = 0;
      hit     = 1'b0;
      gnt_id  = '0;
      gnt_cmd = '0;
      gnt_a   = '0;
      gnt_b   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(rr_q) + k) % N_REQ;
         if (!hit && req_valid[idx]) begin
            hit     = 1'b1;
            gnt_id  = ID_W'(idx);
            gnt_cmd = req_cmd[2*idx +: 2];
            gnt_a   = req_din1[DATA_W*idx +: DATA_W];
            gnt_b   = req_din2[DATA_W*idx +: DATA_W];
         end
      end
   end

   // A ready on the last allowed cycle still counts as a normal completion.
   assign timed_out = !fpu_ready && (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (hit) begin
               state_d = (gnt_cmd == 2'd0) ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (fpu_ready || timed_out) begin
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Op context, watchdog counter, response registers and round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_q   <= '0;
         id_q   <= '0;
         cmd_q  <= '0;
         din1_q <= '0;
         din2_q <= '0;
         res_q  <= '0;
         err_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (hit) begin
                  id_q   <= gnt_id;
                  cmd_q  <= gnt_cmd;
                  din1_q <= gnt_a;
                  din2_q <= gnt_b;
                  // Illegal op skips the FPU; its error response is set up here.
                  if (gnt_cmd == 2'd0) begin
                     res_q <= '0;
                     err_q <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               cnt_q <= '0;
            end
            S_WAIT: begin
               if (fpu_ready) begin
                  res_q <= fpu_result;
                  err_q <= 1'b0;
               end else if (timed_out) begin
                  res_q <= '0;
                  err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_RESP: begin
               // The requester just served drops to lowest priority.
               rr_q <= next_ptr(id_q);
            end
            default: ;
         endcase
      end
   end

   assign req_ready  = (state_q == S_IDLE && hit) ? onehot(gnt_id) : '0;
   assign rsp_valid  = (state_q == S_RESP) ? onehot(id_q) : '0;
   assign rsp_result = res_q;
   assign rsp_err    = err_q;
   assign busy       = (state_q != S_IDLE);
   assign fpu_valid  = (state_q == S_ISSUE);
   assign fpu_cmd    = (state_q == S_ISSUE || state_q == S_WAIT) ? cmd_q : 2'd0;
   assign fpu_din1   = din1_q;
   assign fpu_din2   = din2_q;

endmodule

// File: tb/tb_fpu_req_arbiter.sv
module tb_fpu_req_arbiter;

   localparam int N_REQ   = 2;
   localparam int TIMEOUT = 16;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [N_REQ-1:0]      req_valid;
   logic [2*N_REQ-1:0]    req_cmd;
   logic [32*N_REQ-1:0]   req_din1;
   logic [32*N_REQ-1:0]   req_din2;
   logic [N_REQ-1:0]      req_ready;
   logic [N_REQ-1:0]      rsp_valid;
   logic [31:0]           rsp_result;
   logic                  rsp_err;
   logic                  busy;
   logic [1:0]            fpu_cmd;
   logic [31:0]           fpu_din1;
   logic [31:0]           fpu_din2;
   logic                  fpu_valid;
   logic                  fpu_ready;
   logic [31:0]           fpu_result;

   fpu_req_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_cmd(req_cmd),
      .req_din1(req_din1), .req_din2(req_din2),
      .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
      .fpu_cmd(fpu_cmd), .fpu_din1(fpu_din1), .fpu_din2(fpu_din2),
      .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_result(fpu_result)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] F1 = 32'h3F800000;
   localparam logic [31:0] F2 = 32'h40000000;
   localparam logic [31:0] F3 = 32'h40400000;
   localparam logic [31:0] F6 = 32'h40C00000;

   typedef struct {
      int          id;
      logic [31:0] res;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   int          stub_lat   = 2;
   bit          stub_never = 1'b0;
   int          fv_count   = 0;
   int          fv_cyc     = 0;
   logic [1:0]  s_cmd;
   logic [31:0] s_a, s_b;
   int          s_lat;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Reference FPU results for the operand pairs used here.
   function automatic logic [31:0] fpu_model(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
      if (c == 2'd1 && a == F1 && b == F2) return F3;
      if (c == 2'd2 && a == F2 && b == F3) return F6;
      if (c == 2'd3 && a == F6 && b == F2) return F3;
      return 32'hDEADBEEF;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // FPU stub: answers each fpu_valid after stub_lat cycles, checks operands held.
   initial begin
      fpu_ready  = 1'b0;
      fpu_result = '0;
      forever begin
         @(negedge clk);
         if (fpu_valid === 1'b1) begin
            fv_count++;
            fv_cyc = cyc;
            s_cmd  = fpu_cmd;
            s_a    = fpu_din1;
            s_b    = fpu_din2;
            s_lat  = stub_lat;
            if (!stub_never) begin
               for (int k = 1; k < s_lat; k++) begin
                  @(negedge clk);
                  if (busy && rsp_valid == '0) begin
                     check("fpu_cmd_hold", 32'(fpu_cmd), 32'(s_cmd));
                     check("fpu_din1_hold", fpu_din1, s_a);
                  end
               end
               @(posedge clk);
               #1;
               fpu_ready  = 1'b1;
               fpu_result = fpu_model(s_cmd, s_a, s_b);
               @(negedge clk);
               if (busy && rsp_valid == '0) begin
                  check("fpu_cmd_hold", 32'(fpu_cmd), 32'(s_cmd));
               end
               @(posedge clk);
               #1;
               fpu_ready = 1'b0;
            end
         end
      end
   end

   // Monitor: per-cycle invariants and scoreboard comparison on every response.
   initial forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
         tests++;
         if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) begin
            fails++;
            $display("FAIL onehot: req_ready=%b rsp_valid=%b required at most one bit", req_ready, rsp_valid);
         end
         if (!busy) begin
            check("idle_fpu_cmd", 32'(fpu_cmd), 32'd0);
         end
         if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL rsp_unexpected: rsp_valid=%b required none", rsp_valid);
            end else begin
               mon_e = sb.pop_front();
               check("rsp_id", 32'(rsp_valid), 32'(1) << mon_e.id);
               check("rsp_result", rsp_result, mon_e.res);
               check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
               check("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
         end
      end
   end

   task automatic wait_grant(input int id, output int t, output bit ok);
      ok = 1'b0;
      t  = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (req_ready[id]) begin
            t  = cyc;
            ok = 1'b1;
            return;
         end
      end
      tests++;
      fails++;
      $display("FAIL grant_timeout: req_ready[%0d] got 0 required 1", id);
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (sb.size() == 0) return;
      end
      tests++;
      fails++;
      $display("FAIL rsp_timeout: %0d responses outstanding required 0", sb.size());
      sb.delete();
   endtask

   task automatic set_req(input int id, input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
      req_cmd[2*id +: 2]   = c;
      req_din1[32*id +: 32] = a;
      req_din2[32*id +: 32] = b;
      req_valid[id]         = 1'b1;
   endtask

   // One single-requester op; expected response pushed at accept time.
   task automatic do_req(input int id, input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] exp_res, input logic exp_err);
      int  t;
      bit  ok;
      int  fv0;
      exp_t e;
      stub_lat = lat;
      fv0      = fv_count;
      @(posedge clk);
      #1;
      set_req(id, c, a, b);
      wait_grant(id, t, ok);
      if (ok) begin
         e.id  = id;
         e.res = exp_res;
         e.err = exp_err;
         e.cyc = (c == 2'd0) ? t + 1 : t + 2 + lat;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid[id] = 1'b0;
      wait_drain();
      repeat (3) @(negedge clk);
      if (ok) begin
         check("fpu_valid_count", 32'(fv_count - fv0), (c == 2'd0) ? 32'd0 : 32'd1);
         if (c != 2'd0) check("fpu_valid_cycle", 32'(fv_cyc), 32'(t + 1));
      end
   endtask

   initial begin
      int   t0, t1, g, gc;
      bit   ok;
      exp_t e;
      reset     = 1'b1;
      req_valid = '0;
      req_cmd   = '0;
      req_din1  = '0;
      req_din2  = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fpu_valid", 32'(fpu_valid), 32'd0);
      check("rst_fpu_cmd", 32'(fpu_cmd), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_result", rsp_result, 32'd0);

      // 1: ADD 1.0 + 2.0
      do_req(0, 2'd1, F1, F2, 2, F3, 1'b0);

      // 2: MUL 2*3, then DIV 6/2 on requester 1
      do_req(1, 2'd2, F2, F3, 3, F6, 1'b0);
      do_req(1, 2'd3, F6, F2, 1, F3, 1'b0);

      // 3: both held valid, pointer at 0 -> alternating grants
      stub_lat = 2;
      @(posedge clk);
      #1;
      set_req(0, 2'd1, F1, F2);
      set_req(1, 2'd2, F2, F3);
      for (int k = 0; k < 6; k++) begin
         gc = -1;
         for (int j = 0; j < 100 && gc < 0; j++) begin
            @(negedge clk);
            if (req_ready != '0) gc = cyc;
         end
         if (gc < 0) begin
            tests++;
            fails++;
            $display("FAIL rr_grant_timeout: grant %0d got none required one", k);
         end else begin
            g = req_ready[1] ? 1 : 0;
            check("rr_order", 32'(g), 32'(k % 2));
            e.id  = g;
            e.res = g ? F6 : F3;
            e.err = 1'b0;
            e.cyc = gc + 4;
            sb.push_back(e);
         end
         if (k == 5) begin
            @(posedge clk);
            #1;
            req_valid = '0;
         end
      end
      req_valid = '0;
      wait_drain();

      // 4: illegal command
      do_req(0, 2'd0, F1, F2, 2, 32'd0, 1'b1);

      // 5: watchdog abort on requester 1, late ready ignored, queued requester 0 served
      stub_lat = 18;
      @(posedge clk);
      #1;
      set_req(1, 2'd2, F2, F3);
      set_req(0, 2'd1, F1, F2);
      wait_grant(1, t1, ok);
      if (ok) begin
         e.id  = 1;
         e.res = 32'd0;
         e.err = 1'b1;
         e.cyc = t1 + 18;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      repeat (3) @(posedge clk);
      stub_lat = 2;
      wait_grant(0, t0, ok);
      if (ok) begin
         check("timeout_next_grant", 32'(t0), 32'(t1 + 19));
         e.id  = 0;
         e.res = F3;
         e.err = 1'b0;
         e.cyc = t0 + 4;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      wait_drain();
      if (ok) check("timeout_next_fpu_valid", 32'(fv_cyc), 32'(t0 + 1));

      // 6: reset during WAIT discards the op; re-issued ADD completes
      stub_never = 1'b1;
      @(posedge clk);
      #1;
      set_req(0, 2'd1, F1, F2);
      wait_grant(0, t0, ok);
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_fpu_valid", 32'(fpu_valid), 32'd0);
      check("midrst_fpu_cmd", 32'(fpu_cmd), 32'd0);
      check("midrst_fpu_din1", fpu_din1, 32'd0);
      check("midrst_fpu_din2", fpu_din2, 32'd0);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd0);
      check("midrst_rsp_result", rsp_result, 32'd0);
      check("midrst_rsp_err", 32'(rsp_err), 32'd0);
      repeat (20) @(negedge clk);
      stub_never = 1'b0;
      do_req(0, 2'd1, F1, F2, 3, F3, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
